instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//   Encodes structured instruction requests (class + fields) into 32-bit RV32I words
//   for the classes the core's main control decodes: R-type, I-type ALU, load, store, beq.
//   Output is registered with a valid/ready handshake and tagged with a sequential
//   instruction-memory word address. Feeds the imem loader and self-test program generators.
// PARAMETERS
//   ADDR_W     8   width of out_addr (word address into instruction memory)
//   BASE_ADDR  0   first word address issued after reset (ADDR_W bits)
// PORTS
//   clk        in   1       clock, all state on rising edge
//   reset_n    in   1       asynchronous active-low reset
//   in_valid   in   1       request valid
//   in_ready   out  1       request accepted when in_valid && in_ready
//   in_cls     in   3       0=R 1=I-ALU 2=LOAD 3=STORE 4=BEQ; 5..7 illegal
//   in_funct3  in   3       funct3 field
//   in_funct7  in   7       funct7 field (R only)
//   in_rd      in   5       destination reg (R/I/LOAD)
//   in_rs1     in   5       source reg 1
//   in_rs2     in   5       source reg 2 (R/STORE/BEQ)
//   in_imm     in   13      immediate; I/LOAD/STORE use [11:0], BEQ uses [12:1]
//   out_valid  out  1       encoded word valid
//   out_ready  in   1       consumer ready
//   out_instr  out  32      encoded instruction
//   out_addr   out  ADDR_W  word address of out_instr
//   err        out  1       one-cycle pulse: illegal request dropped
//   wrapped    out  1       sticky: address counter wrapped past all-ones
// BEHAVIOUR
//   Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, wrapped=0, next_addr=BASE_ADDR.
//   Reset mid-operation discards any held word; no partial output.
//   in_ready = !out_valid || out_ready (combinational; single output register).
//   Legal accept at edge N -> out_valid=1, out_instr, out_addr=next_addr visible after edge N;
//   latency 1 cycle. next_addr increments by 1 per legal accept.
//   Output handshake (out_valid && out_ready) with no accept same edge -> out_valid=0.
//   Simultaneous output handshake + legal accept -> register reloads, out_valid stays 1.
//   out_instr/out_addr held stable while out_valid && !out_ready.
//   Encodings (opcode in [6:0]):
//     R:     funct7|rs2|rs1|funct3|rd|0110011
//     I:     imm[11:0]|rs1|funct3|rd|0010011
//     LOAD:  imm[11:0]|rs1|funct3|rd|0000011
//     STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011
//     BEQ:   imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011
//   Unused fields for a class are ignored; imm[12] ignored for I/LOAD/STORE.
//   Illegal: in_cls>=5, or BEQ with imm[0]=1. Illegal requests are accepted (handshake
//   completes), produce no output word, do not advance next_addr; err=1 for exactly the
//   cycle after accept. Illegal accept on the same edge as an output handshake -> out_valid=0.
//   Wrap: next_addr at 2^ADDR_W-1 issues that address, then becomes 0 and wrapped=1
//   (sticky until reset). Encoding is purely field packing; no sign/range checks beyond above.
// TESTING
//   R add x3,x1,x2 (cls0,f7=0,f3=0), out_ready=1 -> out_instr=32'h002081B3, out_addr=0, 1-cycle latency.
//   I addi x5,x0,-1 (cls1,imm=13'h1FFF) -> 32'hFFF00293; LOAD lw x6,8(x2) -> 32'h00812303.
//   STORE sw x7,-4(x2) -> 32'hFE712E23; BEQ x1,x2,+16 -> 32'h00208863; addresses 0,1,2,...
//   Backpressure: out_ready=0 for 5 cycles after one accept -> in_ready=0, outputs stable;
//   release with in_valid held -> back-to-back words, out_valid continuous.
//   Illegal cls=6 then BEQ imm=13'h0003 -> err pulses twice, no out_valid, next legal gets prior address.
//   ADDR_W=2: issue 5 words -> addrs 0,1,2,3,0; wrapped=1 after 4th; reset_n low mid-stall clears all.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs class + fields into a 32-bit word, registered
// behind a valid/ready handshake and tagged with a sequential imem word address.
module instr_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_cls,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic              wrapped
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic [31:0]       enc;
    logic              illegal;
    logic              accept;
    logic              legal_acc;
    logic [ADDR_W-1:0] next_addr;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign legal_acc = accept && !illegal;

    // Misaligned branch offsets (imm[0]=1) cannot be encoded, so they are rejected.
    always_comb begin
        enc     = '0;
        illegal = 1'b0;
        case (in_cls)
            3'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            3'd1: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
            3'd2: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            3'd3: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            3'd4: begin
                enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], OP_BEQ};
                illegal = in_imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            next_addr <= BASE_ADDR;
            err       <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            err <= accept && illegal;
            if (legal_acc) begin
                out_valid <= 1'b1;
                out_instr <= enc;
                out_addr  <= next_addr;
                next_addr <= next_addr + ADDR_W'(1);
                if (&next_addr)
                    wrapped <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: spec vectors, handshake corner cases and
// randomized traffic against a transaction-level reference model (two address widths).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_cls = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [12:0] in_imm = '0;
    logic        out_ready = 1'b1;

    logic        rdy8, vld8, err8, wrp8;
    logic [31:0] ins8;
    logic [7:0]  adr8;
    logic        rdy2, vld2, err2, wrp2;
    logic [31:0] ins2;
    logic [1:0]  adr2;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy8),
        .in_cls(in_cls), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(vld8),
        .out_ready(out_ready), .out_instr(ins8), .out_addr(adr8), .err(err8), .wrapped(wrp8));

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_cls(in_cls), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(vld2),
        .out_ready(out_ready), .out_instr(ins2), .out_addr(adr2), .err(err2), .wrapped(wrp2));

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: one output slot plus a count of words issued since reset.
    bit        m_vld;
    bit [31:0] m_ins;
    int        m_idx;
    int        m_cnt;
    bit        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit [31:0] model_enc(input int cls, input int f3, input int f7, input int rd,
                                            input int rs1, input int rs2, input int imm);
        bit [31:0] w;
        w = (rs1 << 15) + (f3 << 12);
        case (cls)
            0: w += (f7 << 25) + (rs2 << 20) + (rd << 7) + 'h33;
            1: w += ((imm % 4096) << 20) + (rd << 7) + 'h13;
            2: w += ((imm % 4096) << 20) + (rd << 7) + 'h03;
            3: w += (((imm / 32) % 128) << 25) + (rs2 << 20) + ((imm % 32) << 7) + 'h23;
            default: w += (((imm / 4096) % 2) << 31) + (((imm / 32) % 64) << 25) + (rs2 << 20)
                          + (((imm / 2) % 16) << 8) + (((imm / 2048) % 2) << 7) + 'h63;
        endcase
        return w;
    endfunction

    function automatic bit model_legal(input int cls, input int imm);
        return (cls < 4) || (cls == 4 && (imm % 2) == 0);
    endfunction

    task automatic set_req(input bit v, input int cls, input int f3, input int f7, input int rd,
                           input int rs1, input int rs2, input int imm);
        in_valid = v; in_cls = 3'(cls); in_funct3 = 3'(f3); in_funct7 = 7'(f7);
        in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 13'(imm);
    endtask

    task automatic check_outputs();
        chk("out_valid8", 32'(vld8), 32'(m_vld));
        chk("out_valid2", 32'(vld2), 32'(m_vld));
        chk("err8", 32'(err8), 32'(m_err));
        chk("err2", 32'(err2), 32'(m_err));
        chk("wrapped8", 32'(wrp8), 32'(m_cnt >= 256));
        chk("wrapped2", 32'(wrp2), 32'(m_cnt >= 4));
        if (m_vld) begin
            chk("out_instr8", ins8, m_ins);
            chk("out_instr2", ins2, m_ins);
            chk("out_addr8", 32'(adr8), 32'(m_idx % 256));
            chk("out_addr2", 32'(adr2), 32'(m_idx % 4));
        end
    endtask

    task automatic cycle();
        bit exp_rdy, acc, legal;
        @(negedge clk);
        exp_rdy = !m_vld || out_ready;
        chk("in_ready8", 32'(rdy8), 32'(exp_rdy));
        chk("in_ready2", 32'(rdy2), 32'(exp_rdy));
        acc   = in_valid && exp_rdy;
        legal = model_legal(in_cls, in_imm);
        @(posedge clk);
        #1;
        if (acc && legal) begin
            m_ins = model_enc(in_cls, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
            m_idx = m_cnt;
            m_cnt++;
            m_vld = 1'b1;
        end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
        end
        m_err = acc && !legal;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        #2;
        m_vld = 0; m_ins = 0; m_idx = 0; m_cnt = 0; m_err = 0;
        chk("rst_valid", 32'({vld8, vld2}), 32'd0);
        chk("rst_instr8", ins8, 32'd0);
        chk("rst_addr", 32'({adr8, adr2}), 32'd0);
        chk("rst_err_wrap", 32'({err8, err2, wrp8, wrp2}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int cls, f3, f7, rd, rs1, rs2, imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 0, 'h00, 3, 1, 2, 0,      32'h002081B3}; // add x3,x1,x2
        vecs[1] = '{1, 0, 0,    5, 0, 0, 'h1FFF, 32'hFFF00293}; // addi x5,x0,-1
        vecs[2] = '{2, 2, 0,    6, 2, 0, 8,      32'h00812303}; // lw x6,8(x2)
        vecs[3] = '{3, 2, 0,    0, 2, 7, 'h1FFC, 32'hFE712E23}; // sw x7,-4(x2)
        vecs[4] = '{4, 0, 0,    0, 1, 2, 16,     32'h00208863}; // beq x1,x2,+16
        vecs[5] = '{0, 0, 'h20, 3, 1, 2, 0,      32'h402081B3}; // sub x3,x1,x2
        vecs[6] = '{1, 0, 0,    5, 0, 0, 'h1005, 32'h00500293}; // imm[12] ignored
        vecs[7] = '{4, 0, 0,    0, 0, 0, 'h1FFC, 32'hFE000EE3}; // beq x0,x0,-4

        do_reset();

        // Spec vectors, one per cycle, consumer always ready
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            set_req(1, vecs[i].cls, vecs[i].f3, vecs[i].f7, vecs[i].rd,
                    vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            cycle();
            chk("tbl_instr", ins8, vecs[i].exp);
            chk("tbl_addr", 32'(adr8), 32'(i));
        end
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Backpressure: one accept, then 5 stalled cycles with a new request held
        do_reset();
        out_ready = 1'b0;
        set_req(1, 0, 0, 0, 3, 1, 2, 0);
        cycle();
        set_req(1, 1, 0, 0, 9, 4, 0, 'h123);
        repeat (5) begin
            cycle();
            chk("stall_hold", ins8, 32'h002081B3);
        end
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("b2b_valid", 32'(vld8), 32'd1);
        chk("b2b_addr", 32'(adr8), 32'd3);

        // Illegal class then misaligned BEQ, then a legal word reuses the next address
        set_req(1, 6, 0, 0, 1, 1, 1, 0);
        cycle();
        set_req(1, 4, 0, 0, 0, 1, 2, 'h0003);
        cycle();
        chk("illegal_err", 32'(err8), 32'd1);
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("illegal_noword", 32'(vld8), 32'd0);
        set_req(1, 2, 2, 0, 6, 2, 0, 8);
        cycle();
        chk("after_illegal_addr", 32'(adr8), 32'd4);

        // Wrap on the 2-bit DUT, then reset while stalled
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(1, 1, 0, 0, i, 0, 0, i);
            cycle();
            chk("wrap_addr2", 32'(adr2), 32'(i % 4));
            chk("wrap_flag2", 32'(wrp2), 32'(i >= 3));
        end
        out_ready = 1'b0;
        cycle();
        cycle();
        do_reset();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_req($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 8191));
            out_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
